beta_ifetch: RTL and testbench

//  Instruction fetch stage for the Beta core. Sits directly upstream of the Beta

---
 rtl/beta_ifetch_if.sv | 25 ++
 rtl/beta_ifetch.sv | 111 +++++++++++
 tb/tb_beta_ifetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/beta_ifetch_if.sv
// Bus bundle between the Beta fetch stage, instruction memory and decode.
// The master side is the fetch stage; the slave side is memory + consumer + redirect source.
interface beta_ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, INSTR, INSTR_PC, instr_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, INSTR, INSTR_PC, instr_valid,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/beta_ifetch.sv
// Beta instruction fetch: credit-limited in-order requests, prefetch FIFO,
// PC-tagged output handshake and redirect flush with stale-response dropping.
module beta_ifetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    beta_ifetch_if.master bus
);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   ONE_C    = CW'(1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_fifo_pc    [DEPTH];

    logic [CW:0]   w_used;
    logic          w_valid;
    logic          w_issue;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redir_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit counts both buffered words and requests still in flight.
    assign w_used     = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_valid    = (r_count != '0);
    assign w_issue    = bus.imem_req & bus.imem_gnt;
    assign w_resp     = bus.imem_rvalid & (r_outstanding != '0);
    assign w_drop     = w_resp & (r_drop_cnt != '0);
    assign w_push     = w_resp & ~w_drop & ~bus.redirect;
    assign w_pop      = w_valid & bus.instr_ready;
    assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    assign bus.imem_req    = (w_used < DEPTH_W) & ~bus.redirect & ~RST;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = w_valid;
    assign bus.INSTR       = w_valid ? r_fifo_instr[r_rptr] : 32'h0;
    assign bus.INSTR_PC    = w_valid ? r_fifo_pc[r_rptr]    : 32'h0;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else if (bus.redirect) begin
            // Every request still in flight after this edge is now stale.
            r_fetch_pc    <= w_redir_pc;
            r_resp_pc     <= w_redir_pc;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_outstanding <= r_outstanding - CW'(w_resp);
            r_drop_cnt    <= r_outstanding - CW'(w_resp);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - ONE_C;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wptr    <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: FIFO storage has no reset; r_count gates every read, so stale contents are never seen.
    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_fifo_instr[r_wptr] <= bus.imem_rdata;
            r_fifo_pc[r_wptr]    <= r_resp_pc;
        end
    end

    a_no_orphan_resp: assert property (@(posedge CLK) disable iff (RST)
        !(bus.imem_rvalid && (r_outstanding == '0)))
        else $error("beta_ifetch: imem_rvalid with no outstanding request");

    a_credit_bound: assert property (@(posedge CLK) disable iff (RST) (w_used <= DEPTH_W))
        else $error("beta_ifetch: outstanding + fifo_count exceeds DEPTH");

    a_drop_bound: assert property (@(posedge CLK) disable iff (RST) (r_drop_cnt <= r_outstanding))
        else $error("beta_ifetch: drop_cnt exceeds outstanding");
endmodule

// File: tb/tb_beta_ifetch.sv
// Bench for beta_ifetch: in-order memory model with variable latency and a
// scoreboard of {instr, pc} pushed at grant time and popped at each handshake.
module tb_beta_ifetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    beta_ifetch_if bus ();

    beta_ifetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    mem_req_t    mem_q[$];
    logic [63:0] sb_q[$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          cyc       = 0;
    int          lat       = 1;
    int          grants    = 0;
    logic [31:0] exp_fetch = RESET_PC;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        #1;
        check("redir_req_low", 64'(bus.imem_req), 64'd0);
        @(negedge CLK);
        bus.redirect = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.instr_valid && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 64'(bus.instr_valid), 64'd1);
    endtask

    // Memory model and scoreboard, sampled at the active edge.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (RST) begin
                mem_q.delete();
                sb_q.delete();
                exp_fetch = RESET_PC;
                grants    = 0;
            end else begin
                if (bus.imem_rvalid) void'(mem_q.pop_front());
                if (bus.redirect) begin
                    sb_q.delete();
                    exp_fetch = bus.redirect_pc & 32'hFFFF_FFFC;
                    grants    = 0;
                end else begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        logic [63:0] e;
                        check("pop_sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            check("pop_entry", {bus.INSTR, bus.INSTR_PC}, e);
                        end
                    end
                    if (bus.imem_req && bus.imem_gnt) begin
                        check("grant_addr", 64'(bus.imem_addr), 64'(exp_fetch));
                        sb_q.push_back({word_of(exp_fetch), exp_fetch});
                        mem_q.push_back('{addr: bus.imem_addr, due: cyc + lat - 1});
                        exp_fetch += 32'd4;
                        grants++;
                    end
                end
            end
            #1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = word_of(mem_q[0].addr);
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'h0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (!bus.instr_valid) check("idle_zero", {bus.INSTR, bus.INSTR_PC}, 64'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bool_found: begin end
        bus.imem_gnt    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (3) @(negedge CLK);
        check("rst_req",   64'(bus.imem_req),    64'd0);
        check("rst_addr",  64'(bus.imem_addr),   64'(RESET_PC));
        check("rst_valid", 64'(bus.instr_valid), 64'd0);

        // Sequential fetch from the reset vector with a 1-cycle memory.
        lat             = 1;
        bus.imem_gnt    = 1'b1;
        bus.instr_ready = 1'b1;
        RST             = 1'b0;
        #1;
        check("t1_req",   64'(bus.imem_req),  64'd1);
        check("t1_addr0", 64'(bus.imem_addr), 64'h8000_0000);
        @(negedge CLK);
        check("t1_addr1",  64'(bus.imem_addr),   64'h8000_0004);
        check("t1_valid0", 64'(bus.instr_valid), 64'd0);
        @(negedge CLK);
        check("t1_addr2",  64'(bus.imem_addr),   64'h8000_0008);
        check("t1_valid1", 64'(bus.instr_valid), 64'd1);
        check("t1_pc",     64'(bus.INSTR_PC),    64'h8000_0000);
        check("t1_instr",  64'(bus.INSTR),       64'(word_of(32'h8000_0000)));
        repeat (5) @(negedge CLK);

        // Consumer stalled: credit caps fetch at four words.
        bus.instr_ready = 1'b0;
        do_redirect(32'h0000_2000);
        repeat (12) @(negedge CLK);
        check("t2_grants", 64'(grants),          64'd4);
        check("t2_req",    64'(bus.imem_req),    64'd0);
        check("t2_valid",  64'(bus.instr_valid), 64'd1);
        check("t2_head",   64'(bus.INSTR_PC),    64'h0000_2000);
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge CLK);
        check("t2_resume", 64'(grants > 4), 64'd1);

        // Redirect with two requests in flight on a 2-cycle memory.
        lat = 2;
        repeat (8) @(negedge CLK);
        check("t3_inflight", 64'(mem_q.size()), 64'd2);
        do_redirect(32'h0000_0103);
        check("t3_addr", 64'(bus.imem_addr), 64'h0000_0100);
        wait_valid("t3_valid", 20);
        check("t3_first_pc", 64'(bus.INSTR_PC), 64'h0000_0100);

        // Redirect colliding with a response and a pop.
        repeat (8) @(negedge CLK);
        check("t4_setup_rvalid", 64'(bus.imem_rvalid), 64'd1);
        check("t4_setup_valid",  64'(bus.instr_valid), 64'd1);
        do_redirect(32'h0000_3000);
        check("t4_empty",    64'(bus.instr_valid), 64'd0);
        check("t4_drop_cnt", 64'(dut.r_drop_cnt),  64'd1);
        wait_valid("t4_valid", 20);
        check("t4_first_pc", 64'(bus.INSTR_PC), 64'h0000_3000);

        // Address wrap at the top of the space.
        lat = 1;
        do_redirect(32'hFFFF_FFF8);
        check("t5_addr_f8", 64'(bus.imem_addr), 64'hFFFF_FFF8);
        repeat (2) @(negedge CLK);
        check("t5_wrap_addr", 64'(bus.imem_addr), 64'h0000_0000);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                if (bus.instr_valid && bus.INSTR_PC == 32'h0) seen = 1'b1;
                else @(negedge CLK);
            end
            check("t5_wrap_pc", 64'(seen), 64'd1);
        end
        repeat (4) @(negedge CLK);

        // Reset with three buffered words and one in flight.
        bus.instr_ready = 1'b0;
        do_redirect(32'h0000_4000);
        for (int i = 0; i < 20 && grants < 4; i++) @(negedge CLK);
        check("t6_grants",   64'(grants),          64'd4);
        check("t6_inflight", 64'(mem_q.size()),    64'd1);
        check("t6_buffered", 64'(bus.instr_valid), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("t6_valid", 64'(bus.instr_valid), 64'd0);
        check("t6_addr",  64'(bus.imem_addr),   64'(RESET_PC));
        check("t6_req0",  64'(bus.imem_req),    64'd0);
        RST = 1'b0;
        #1;
        check("t6_req1", 64'(bus.imem_req), 64'd1);
        bus.instr_ready = 1'b1;
        wait_valid("t6_restart", 20);
        check("t6_first_pc", 64'(bus.INSTR_PC), 64'(RESET_PC));
        repeat (6) @(negedge CLK);

        // Stop granting and drain everything that was fetched.
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 20 && (sb_q.size() > 0 || mem_q.size() > 0); i++) @(negedge CLK);
        @(negedge CLK);
        check("drain_sb",    64'(sb_q.size()),     64'd0);
        check("drain_valid", 64'(bus.instr_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
